// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: synchroniser, start-edge detect, 3-sample majority
// vote, configurable data/parity/stop framing, error flags and valid/ready output.
module uart_rx_param #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned PARITY_ODD   = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_pin_in,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det,
  output logic                 overrun_err,
  output logic                 rx_busy
);

  localparam int unsigned MID   = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W = $clog2(DATA_BITS);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;

  state_t state, state_n;

  logic                 sync1, sync2, prev;
  logic [CNT_W-1:0]     cnt;
  logic                 samp_a, samp_b;
  logic [IDX_W-1:0]     idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] data_sr;
  logic                 par_bit;
  logic                 done, done_perr, done_ferr, done_brk;

  logic fall, tick, maj, stop_last, frame_end, perr_calc;

  // Line synchroniser and previous-sample flop; idle-high after reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      prev  <= 1'b1;
    end else begin
      sync1 <= rx_pin_in;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign fall      = prev & ~sync2;
  assign tick      = (state != IDLE) && (state != WAIT_HIGH) && (cnt == CNT_W'(MID + 1));
  assign maj       = (samp_a & samp_b) | (samp_a & sync2) | (samp_b & sync2);
  assign stop_last = (stop_idx == 1'(STOP_BITS - 1));
  assign frame_end = (state == STOP) && tick && (!maj || stop_last);
  assign perr_calc = (PARITY_EN != 0) && ((^data_sr) ^ par_bit ^ (PARITY_ODD != 0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:      if (fall) state_n = START;
      START:     if (tick) state_n = maj ? IDLE : DATA;
      DATA:      if (tick && (idx == IDX_W'(DATA_BITS - 1)))
                   state_n = (PARITY_EN != 0) ? PARITY : STOP;
      PARITY:    if (tick) state_n = STOP;
      STOP: begin
        // completion at the last stop-bit mid-point so back-to-back frames resync
        if (tick) begin
          if (!maj)           state_n = WAIT_HIGH;
          else if (stop_last) state_n = IDLE;
        end
      end
      WAIT_HIGH: if (sync2) state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end

  // Bit timer, majority samples and frame assembly
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      samp_a    <= 1'b1;
      samp_b    <= 1'b1;
      idx       <= '0;
      stop_idx  <= 1'b0;
      data_sr   <= '0;
      par_bit   <= 1'b0;
      done      <= 1'b0;
      done_perr <= 1'b0;
      done_ferr <= 1'b0;
      done_brk  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE || cnt == CNT_W'(CLKS_PER_BIT - 1)) cnt <= '0;
      else                                                  cnt <= cnt + CNT_W'(1);
      if (cnt == CNT_W'(MID - 1)) samp_a <= sync2;
      if (cnt == CNT_W'(MID))     samp_b <= sync2;

      if (state != DATA)  idx <= '0;
      else if (tick)      idx <= idx + IDX_W'(1);
      if (state == DATA && tick) data_sr <= {maj, data_sr[DATA_BITS-1:1]};

      if (state == IDLE)               par_bit <= 1'b0;
      else if (state == PARITY && tick) par_bit <= maj;

      if (state != STOP) stop_idx <= 1'b0;
      else if (tick)     stop_idx <= ~stop_idx;

      if (frame_end) begin
        done      <= 1'b1;
        done_perr <= perr_calc;
        done_ferr <= ~maj;
        done_brk  <= ~maj & ~stop_idx & (data_sr == '0) & ~par_bit;
      end
    end
  end

  // Output handshake: load on completion when the holding register is free
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      break_det   <= 1'b0;
      overrun_err <= 1'b0;
      rx_busy     <= 1'b0;
    end else begin
      overrun_err <= 1'b0;
      rx_busy     <= (state_n != IDLE);
      if (done && (!rx_valid || rx_ready)) begin
        rx_data    <= data_sr;
        parity_err <= done_perr;
        frame_err  <= done_ferr;
        break_det  <= done_brk;
        rx_valid   <= 1'b1;
      end else if (done) begin
        overrun_err <= 1'b1;
      end else if (rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule
